// File: rtl/mcu_frame_router.sv
// Routes framed MCU bytes to the command target whose (cmd & mask) == base, and returns that target's reply.
// Optional mid-frame idle abort is enabled by defining MCU_FRAME_ROUTER_TIMEOUT_EN.
module mcu_frame_router #(
    parameter int                NT        = 4,
    parameter logic [NT*8-1:0]   CMD_BASE  = {8'h20, 8'h10, 8'h08, 8'h00},
    parameter logic [NT*8-1:0]   CMD_MASK  = {8'hF0, 8'hF0, 8'hF8, 8'hF8},
    parameter logic [7:0]        IDLE_BYTE = 8'hFF,
    parameter logic [15:0]       TIMEOUT   = 16'd50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_in_strobe,
    input  logic                 data_in_start,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic [NT-1:0]        tgt_strobe,
    output logic                 tgt_start,
    output logic [7:0]           tgt_data,
    input  logic [NT*8-1:0]      tgt_dout,
    output logic                 frame_active,
    output logic [2:0]           frame_sel,
    output logic                 frame_unmapped,
    output logic [7:0]           byte_cnt,
    output logic                 err_pulse,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ROUTE   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t          r_state;
    logic [7:0]      r_data_out;
    logic [NT-1:0]   r_tgt_strobe;
    logic            r_tgt_start;
    logic [7:0]      r_tgt_data;
    logic            r_active;
    logic [2:0]      r_sel;
    logic            r_unmapped;
    logic [7:0]      r_byte_cnt;
    logic            r_err;

    logic            w_hit;
    logic [2:0]      w_idx;
    logic [7:0]      w_reply;

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int k = NT - 1; k >= 0; k--) begin
            if ((data_in & CMD_MASK[8*k +: 8]) == CMD_BASE[8*k +: 8]) begin
                w_hit = 1'b1;
                w_idx = 3'(k);
            end
        end
    end

    always_comb begin
        w_reply = IDLE_BYTE;
        for (int k = 0; k < NT; k++) begin
            if (r_sel == 3'(k)) w_reply = tgt_dout[8*k +: 8];
        end
    end

`ifdef MCU_FRAME_ROUTER_TIMEOUT_EN
    logic [15:0] r_idle;
`else
    logic        w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_data_out   <= IDLE_BYTE;
            r_tgt_strobe <= '0;
            r_tgt_start  <= 1'b0;
            r_tgt_data   <= '0;
            r_active     <= 1'b0;
            r_sel        <= '0;
            r_unmapped   <= 1'b0;
            r_byte_cnt   <= '0;
            r_err        <= 1'b0;
`ifdef MCU_FRAME_ROUTER_TIMEOUT_EN
            r_idle       <= '0;
`endif
        end else begin
            r_tgt_strobe <= '0;
            r_tgt_start  <= 1'b0;
            r_err        <= 1'b0;
            r_data_out   <= (r_state == S_ROUTE) ? w_reply : IDLE_BYTE;

            if (data_in_strobe && data_in_start) begin
                r_active   <= 1'b1;
                r_byte_cnt <= 8'd1;
                r_sel      <= w_idx;
                if (w_hit) begin
                    r_state      <= S_ROUTE;
                    r_unmapped   <= 1'b0;
                    r_tgt_strobe <= NT'(1) << w_idx;
                    r_tgt_start  <= 1'b1;
                    r_tgt_data   <= data_in;
                end else begin
                    r_state    <= S_DISCARD;
                    r_unmapped <= 1'b1;
                    r_err      <= 1'b1;
                end
            end else if (data_in_strobe && (r_state != S_IDLE)) begin
                if (r_byte_cnt != 8'hFF) r_byte_cnt <= r_byte_cnt + 8'd1;
                if (r_state == S_ROUTE) begin
                    r_tgt_strobe <= NT'(1) << r_sel;
                    r_tgt_data   <= data_in;
                end
            end

`ifdef MCU_FRAME_ROUTER_TIMEOUT_EN
            // Abort an open frame after TIMEOUT consecutive strobe-free clocks; byte_cnt is kept.
            if (data_in_strobe) begin
                r_idle <= '0;
            end else if (r_state != S_IDLE) begin
                if (r_idle == TIMEOUT - 16'd1) begin
                    r_idle     <= '0;
                    r_state    <= S_IDLE;
                    r_active   <= 1'b0;
                    r_data_out <= IDLE_BYTE;
                    r_err      <= 1'b1;
                end else begin
                    r_idle <= r_idle + 16'd1;
                end
            end
`endif
        end
    end

    assign data_out       = r_data_out;
    assign tgt_strobe     = r_tgt_strobe;
    assign tgt_start      = r_tgt_start;
    assign tgt_data       = r_tgt_data;
    assign frame_active   = r_active;
    assign frame_sel      = r_sel;
    assign frame_unmapped = r_unmapped;
    assign byte_cnt       = r_byte_cnt;
    assign err_pulse      = r_err;
    assign dbg_state      = r_state;

endmodule

// File: doc/mcu_frame_router.md
Name: mcu_frame_router

Overview:
- Arbitrates the single MCU byte stream (strobe/start/data) between up to NT command targets, for example sysctrl, HID, OSD and SD card.
- Decodes the command byte at frame start and forwards the whole frame only to the owning target.
- Muxes that target's reply byte back to the MCU.
- Sits between the MCU SPI deserialiser and all command-handling blocks.

Parameters:
- NT, 4, number of targets (1..8).
- CMD_BASE, {8'h20,8'h10,8'h08,8'h00}, packed NT×8 match values; target k uses bits [8k+7:8k].
- CMD_MASK, {8'hF0,8'hF0,8'hF8,8'hF8}, packed NT×8 masks; target k matches when (cmd & mask_k) == base_k.
- IDLE_BYTE, 8'hFF, reply byte returned when no target owns the frame.
- TIMEOUT, 16'd50000, idle clocks before a mid-frame abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data_in_strobe  in  1  one-cycle pulse per received MCU byte
- data_in_start  in  1  qualifies the strobed byte as the first (command) byte of a frame
- data_in  in  8  received byte
- data_out  out  8  reply byte to MCU (registered)
- tgt_strobe  out  NT  per-target byte strobe (one-hot or zero)
- tgt_start  out  1  start flag accompanying tgt_strobe
- tgt_data  out  8  forwarded byte
- tgt_dout  in  NT×8  per-target reply bytes; target k on [8k+7:8k]
- frame_active  out  1  high while a frame is open
- frame_sel  out  3  index of the owning target; valid while frame_active and not frame_unmapped
- frame_unmapped  out  1  current frame has no owner
- byte_cnt  out  8  bytes received in the current frame, including the command byte; saturates at 255
- err_pulse  out  1  one-cycle pulse when a frame start decodes to no target

Behaviour:
- Reset values:
  - State = IDLE.
  - data_out = IDLE_BYTE, tgt_strobe = 0, tgt_start = 0, tgt_data = 0.
  - frame_active = 0, frame_sel = 0, frame_unmapped = 0, byte_cnt = 0, err_pulse = 0.
- Reset mid-frame aborts the frame. No further tgt_strobe is issued until the next start byte.
- Decode:
  - Combinational on data_in, evaluated at strobe & start.
  - Lowest matching index wins; overlapping maps are legal.
  - No match → unmapped.
- States:
  - IDLE: strobe & start with a match → ROUTE, sel latched. strobe & start with no match → DISCARD, err_pulse. strobe without start is ignored (no forward, counter unchanged).
  - ROUTE: strobe & !start → forward the byte to sel. strobe & start → new frame, re-decode; the previous frame ends implicitly.
  - DISCARD: bytes are counted but not forwarded. strobe & start → re-decode.
- Forwarding latency:
  - A byte strobed in cycle N appears in cycle N+1 as tgt_strobe[sel] = 1, tgt_data = byte, tgt_start = start.
  - The start byte itself goes to the newly selected target.
  - Exactly one target strobes per input strobe; none in DISCARD.
- byte_cnt:
  - Loads 1 on start, increments on each non-start strobe, saturates at 8'hFF.
  - Updates in the same cycle as tgt_strobe (N+1).
- data_out:
  - Registered every cycle from tgt_dout[sel] while in ROUTE; IDLE_BYTE in IDLE or DISCARD.
  - Reply latency is 1 clock after the target updates its own data_out. The MCU reads the reply on the following byte exchange.
- frame_sel, frame_unmapped and frame_active update in cycle N+1 with the start byte.
- Simultaneous reset and strobe: reset wins.
- The strobe input is assumed to be a single-cycle pulse. Back-to-back strobes on consecutive cycles are each forwarded, with the same 1-cycle latency.

Optional Feature:
- MCU_FRAME_ROUTER_TIMEOUT_EN defined:
  - A 16-bit idle counter clears on every strobe and counts while in ROUTE or DISCARD.
  - When it reaches TIMEOUT, state → IDLE, frame_active = 0, data_out = IDLE_BYTE, err_pulse asserts for 1 cycle, byte_cnt is held.
  - Subsequent non-start strobes are ignored.
- Undefined: frames stay open indefinitely until the next start byte. The counter and TIMEOUT logic are absent.

Test Plan:
- Start 8'h04, then bytes 8'h56, 8'h03 → tgt_strobe = 4'b0001 on three consecutive forwards; tgt_start = 1 only on the first; frame_sel = 0; byte_cnt = 1, 2, 3.
- Start 8'h12, with tgt_dout[2] = 8'hA5 → frame_sel = 2; data_out = 8'hA5 one cycle after selection; tgt_strobe[0], [1] and [3] never assert.
- Start 8'h40 (unmapped), then 2 bytes → err_pulse once; no tgt_strobe; data_out = 8'hFF; frame_unmapped = 1; byte_cnt = 3.
- Mid-frame to target 1: new start 8'h00 → next forward goes to target 0 with tgt_start = 1; byte_cnt = 1.
- Assert reset between byte 2 and byte 3 of a frame → all outputs return to reset values; the following non-start byte produces no tgt_strobe.
- With MCU_FRAME_ROUTER_TIMEOUT_EN and TIMEOUT = 16: start 8'h08, wait 16 clocks, send 8'h11 → err_pulse at timeout; frame_active = 0; 8'h11 is not forwarded.
